state_dump_unit: RTL and testbench

Hardware counterpart of the bench-side end-of-run dump. On a start request, walks every general-purpose register and the first data-memory words of the single-cycle CPU and streams each word out over a valid/ready handshake. Sits beside `Simple_Single_CPU`, tapping a spare register-file read port and a data-memory read port, so an on-chip logger or UART bridge can capture final architectural state without hierarchical probes.

---
 rtl/state_dump_unit.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_state_dump_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// ---------------------------------------------------------------------------
// state_dump_unit
//
// Streams the final architectural state of the single-cycle CPU out over a
// valid/ready handshake. On a start request the unit walks every
// general-purpose register through a spare register-file read port. It then
// walks the first MEM_WORDS data-memory words through a data-memory read
// port. Each word is presented with a tag and an index.
//
// Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//   When defined, one extra word follows the last memory word.
//   That word has tag 2'b10 and idx 0. Its data is the modulo-2^DATA_W sum
//   of every word emitted before it.
//   When undefined, no accumulator exists and the dump ends with the last
//   memory word.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous active-high reset
//   start_i      in   1       dump request, honoured only when idle
//   busy_o       out  1       dump in progress
//   done_o       out  1       one-cycle pulse after the final word's transfer
//   rf_addr_o    out  5       register-file read address
//   rf_data_i    in   DATA_W  register-file read data (combinational)
//   dm_addr_o    out  32      data-memory byte address (4 x word index)
//   dm_data_i    in   DATA_W  data-memory read data (combinational)
//   out_valid_o  out  1       output word valid
//   out_ready_i  in   1       consumer ready
//   out_data_o   out  DATA_W  output word
//   out_tag_o    out  2       00 register, 01 memory, 10 checksum
//   out_idx_o    out  5       register / memory word index (0 for checksum)
// ---------------------------------------------------------------------------
module state_dump_unit #(
   parameter int REG_NUM   = 32,
   parameter int MEM_WORDS = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [4:0]        rf_addr_o,
   input  logic [DATA_W-1:0] rf_data_i,
   output logic [31:0]       dm_addr_o,
   input  logic [DATA_W-1:0] dm_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        out_tag_o,
   output logic [4:0]        out_idx_o
);

   // The index counter serves both phases, so it is sized for the larger one.
   // It is never narrower than the 5-bit index ports.
   localparam int MAX_N = (REG_NUM > MEM_WORDS) ? REG_NUM : MEM_WORDS;
   localparam int IDX_W = ($clog2(MAX_N) > 5) ? $clog2(MAX_N) : 5;

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_NUM - 1);
   localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

   localparam logic [1:0] TAG_REG = 2'b00;
   localparam logic [1:0] TAG_MEM = 2'b01;
`ifdef DUMP_CHECKSUM_EN
   localparam logic [1:0] TAG_SUM = 2'b10;
`endif

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REG   = 3'd1,
      ST_MEM   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
`ifdef DUMP_CHECKSUM_EN
      ,
      ST_SUM   = 3'd5
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [1:0]         out_tag_q, out_tag_d;
   logic [4:0]         out_idx_q, out_idx_d;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0]  acc_q, acc_d;
`endif

   logic handshake_s;
   logic slot_free_s;

   // A word leaves on valid && ready. The output register can take a new word
   // when it is empty, or when its current word leaves at this same edge.
   // Loading in that second case is what gives one word per cycle with no
   // bubbles.
   assign handshake_s = out_valid_q & out_ready_i;
   assign slot_free_s = ~out_valid_q | out_ready_i;

   // Read addresses are decoded straight from the registered state and index.
   // The combinational read data is therefore valid in the cycle the word is
   // captured.
   always_comb begin
      rf_addr_o = 5'd0;
      dm_addr_o = 32'd0;
      if (state_q == ST_REG) begin
         rf_addr_o = 5'(idx_q);
         dm_addr_o = 32'd0;
      end else if (state_q == ST_MEM) begin
         rf_addr_o = 5'd0;
         dm_addr_o = 32'(idx_q) << 2;
      end else begin
         rf_addr_o = 5'd0;
         dm_addr_o = 32'd0;
      end
   end

   // Next-state, index, output-slot and status logic for the dump walk.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_idx_d   = out_idx_q;
`ifdef DUMP_CHECKSUM_EN
      acc_d       = acc_q;
`endif
      // A transferred word empties the slot unless a new word is loaded below.
      if (handshake_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_REG;
               idx_d   = IDX_ZERO;
`ifdef DUMP_CHECKSUM_EN
               acc_d   = {DATA_W{1'b0}};
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_REG: begin
            if (slot_free_s) begin
               out_valid_d = 1'b1;
               out_data_d  = rf_data_i;
               out_tag_d   = TAG_REG;
               out_idx_d   = 5'(idx_q);
`ifdef DUMP_CHECKSUM_EN
               acc_d       = acc_q + rf_data_i;
`endif
               if (idx_q == REG_LAST) begin
                  state_d = ST_MEM;
                  idx_d   = IDX_ZERO;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
               end
            end else begin
               state_d = ST_REG;
            end
         end

         ST_MEM: begin
            if (slot_free_s) begin
               out_valid_d = 1'b1;
               out_data_d  = dm_data_i;
               out_tag_d   = TAG_MEM;
               out_idx_d   = 5'(idx_q);
`ifdef DUMP_CHECKSUM_EN
               acc_d       = acc_q + dm_data_i;
`endif
               if (idx_q == MEM_LAST) begin
                  idx_d   = IDX_ZERO;
`ifdef DUMP_CHECKSUM_EN
                  state_d = ST_SUM;
`else
                  state_d = ST_FLUSH;
`endif
               end else begin
                  idx_d   = idx_q + IDX_ONE;
               end
            end else begin
               state_d = ST_MEM;
            end
         end

`ifdef DUMP_CHECKSUM_EN
         ST_SUM: begin
            // acc_q already holds every register and memory word at this point.
            if (slot_free_s) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               out_tag_d   = TAG_SUM;
               out_idx_d   = 5'd0;
               state_d     = ST_FLUSH;
            end else begin
               state_d     = ST_SUM;
            end
         end
`endif

         ST_FLUSH: begin
            // The final word is in the slot. Finish once it has been taken.
            if (handshake_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FLUSH;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            idx_d       = IDX_ZERO;
            out_valid_d = 1'b0;
         end
      endcase

      // The status flags are registered copies of the decoded next state.
      // They therefore line up exactly with the state register.
      case (state_d)
         ST_REG, ST_MEM, ST_FLUSH: busy_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
         ST_SUM:                   busy_d = 1'b1;
`endif
         default:                  busy_d = 1'b0;
      endcase
      if (state_d == ST_DONE) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // State, index, output slot and status registers. Reset aborts any dump.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= IDX_ZERO;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         out_tag_q   <= 2'b00;
         out_idx_q   <= 5'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_idx_q   <= out_idx_d;
      end
   end

`ifdef DUMP_CHECKSUM_EN
   // Running sum of the emitted words, used for the trailing checksum word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= {DATA_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_tag_o   = out_tag_q;
   assign out_idx_o   = out_idx_q;

endmodule

// File: tb/tb_state_dump_unit.sv
module tb_state_dump_unit;

   localparam int NREG = 32;
   localparam int NMEM = 32;
`ifdef DUMP_CHECKSUM_EN
   localparam int TOTAL = NREG + NMEM + 1;
`else
   localparam int TOTAL = NREG + NMEM;
`endif

   typedef struct packed {
      logic [1:0]  tag;
      logic [4:0]  idx;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic [4:0]  out_idx;

   logic [31:0] rf_mem [NREG];
   logic [31:0] dm_mem [NMEM];

   exp_t exp_q [$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   xfer_cnt = 0;
   int   done_cnt = 0;

   state_dump_unit #(.REG_NUM(NREG), .MEM_WORDS(NMEM), .DATA_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .rf_addr_o   (rf_addr),
      .rf_data_i   (rf_data),
      .dm_addr_o   (dm_addr),
      .dm_data_i   (dm_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_tag_o   (out_tag),
      .out_idx_o   (out_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign rf_data = rf_mem[rf_addr];
   assign dm_data = dm_mem[dm_addr[6:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_all();
      logic [31:0] sum;
      sum = 32'd0;
      for (int i = 0; i < NREG; i++) begin
         exp_q.push_back({2'b00, 5'(i), rf_mem[i]});
         sum = sum + rf_mem[i];
      end
      for (int j = 0; j < NMEM; j++) begin
         exp_q.push_back({2'b01, 5'(j), dm_mem[j]});
         sum = sum + dm_mem[j];
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back({2'b10, 5'd0, sum});
`endif
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   // Scoreboard monitor: a word seen valid&&ready mid-cycle transfers at the next edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            exp_t e;
            xfer_cnt++;
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("word_tag", 32'(out_tag), 32'(e.tag));
               check("word_idx", 32'(out_idx), 32'(e.idx));
               check("word_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      int n;
      int base;
      int dbase;
      bit found;
      for (int i = 0; i < NREG; i++) rf_mem[i] = 32'(i + 1);
      for (int j = 0; j < NMEM; j++) dm_mem[j] = 32'(100 + j);

      // Reset held while start pulses
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      #3;
      step();
      start = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_tag", 32'(out_tag), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_rf_addr", 32'(rf_addr), 32'd0);
      check("rst_dm_addr", dm_addr, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      step();
      step();
      check("idle_valid", 32'(out_valid), 32'd0);

      // Full dump with ready held high
      push_all();
      dbase = done_cnt;
      start = 1'b1;
      step();
      n = cyc;
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_valid", 32'(out_valid), 32'd0);
      step();
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data", out_data, 32'd1);
      check("first_tag", 32'(out_tag), 32'd0);
      wait_done(200);
      check("full_done_cycle", 32'(cyc), 32'(n + TOTAL + 1));
      check("full_busy_at_done", 32'(busy), 32'd0);
      step();
      check("full_done_pulse", 32'(done_cnt - dbase), 32'd1);
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);

      // Back-pressure while r5 is presented
      push_all();
      start = 1'b1;
      step();
      n = cyc;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid && out_tag == 2'b00 && out_idx == 5'd5) begin
            found = 1'b1;
            break;
         end
      end
      check("bp_found_r5", 32'(found), 32'd1);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_data", out_data, 32'd6);
         check("bp_tag", 32'(out_tag), 32'd0);
         check("bp_idx", 32'(out_idx), 32'd5);
      end
      out_ready = 1'b1;
      wait_done(200);
      check("bp_done_cycle", 32'(cyc), 32'(n + TOTAL + 1 + 3));
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Start pulsed during the memory phase is ignored
      step();
      push_all();
      dbase = done_cnt;
      base = xfer_cnt;
      start = 1'b1;
      step();
      n = cyc;
      start = 1'b0;
      repeat (40) step();
      check("busy_mid_mem", 32'(busy), 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(200);
      check("sb_done_cycle", 32'(cyc), 32'(n + TOTAL + 1));
      repeat (5) step();
      check("sb_word_count", 32'(xfer_cnt - base), 32'(TOTAL));
      check("sb_done_count", 32'(done_cnt - dbase), 32'd1);
      check("sb_idle_busy", 32'(busy), 32'd0);
      check("sb_idle_valid", 32'(out_valid), 32'd0);

      // Reset mid-dump after 10 transfers
      push_all();
      base = xfer_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (xfer_cnt - base >= 10) break;
         step();
      end
      check("mid_xfers", 32'(xfer_cnt - base), 32'd10);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      check("post_rst_valid", 32'(out_valid), 32'd0);

      // New full dump after the abort
      push_all();
      base = xfer_cnt;
      start = 1'b1;
      step();
      n = cyc;
      start = 1'b0;
      step();
      check("restart_idx", 32'(out_idx), 32'd0);
      check("restart_data", out_data, 32'd1);
      wait_done(200);
      check("restart_done_cycle", 32'(cyc), 32'(n + TOTAL + 1));
      step();
      check("restart_words", 32'(xfer_cnt - base), 32'(TOTAL));
      check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
